// File: rtl/ahb_apb_bridge_mp_pkg.sv
// Shared encodings and FSM state type for the parametrised AHB-to-APB bridge.
package ahb_apb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETUP,
    ACCESS,
    DONE,
    MISS,
    ERR1,
    ERR2
  } bridge_state_t;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are no-ops.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: slave-index field of the registered address to
// a one-hot select, plus a miss flag when the index names no existing slave.
module apb_addr_decode #(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SLV_LSB    = 12,
  parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  miss
);

  // One extra bit so NUM_SLAVES itself is representable for the compare.
  localparam logic [SEL_W:0] NUM_S = (SEL_W + 1)'(NUM_SLAVES);

  logic [SEL_W-1:0] idx;
  logic             unused_addr;

  assign idx         = addr[SLV_LSB +: SEL_W];
  assign miss        = ({1'b0, idx} >= NUM_S);
  assign unused_addr = ^addr;

  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!miss && (idx == SEL_W'(i))) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_mp.sv
// Parametrised AHB-to-APB3 bridge with wait states and back-to-back accepts.
// Define BRIDGE_PSLVERR_EN for two-cycle AHB ERROR on pslverr / decode miss.
module ahb_apb_bridge_mp
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SLV_LSB    = 12,
  parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hwrite,
  input  logic                  hreadyin,
  input  logic [1:0]            htrans,
  input  logic [ADDR_W-1:0]     haddr,
  input  logic [DATA_W-1:0]     hwdata,
  output logic [DATA_W-1:0]     hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata
);

  bridge_state_t         state;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_miss;
  logic                  accept;

  // paddr doubles as the address-phase capture register, so decode reads it.
  apb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_SLAVES(NUM_SLAVES),
    .SLV_LSB   (SLV_LSB),
    .SEL_W     (SEL_W)
  ) u_decode (
    .addr(paddr),
    .sel (dec_sel),
    .miss(dec_miss)
  );

  assign accept = hreadyin && is_active(htrans);

`ifndef BRIDGE_PSLVERR_EN
  logic unused_pslverr;
  assign unused_pslverr = pslverr;
  assign hresp          = RESP_OKAY;
`endif

  // hresetn is active-high and synchronous despite its name.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state     <= IDLE;
      hreadyout <= 1'b1;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hrdata    <= '0;
`ifdef BRIDGE_PSLVERR_EN
      hresp     <= RESP_OKAY;
`endif
    end else begin
      case (state)
        IDLE, DONE, MISS: begin
          if (accept) begin
            state     <= LATCH;
            paddr     <= haddr;
            pwrite    <= hwrite;
            hreadyout <= 1'b0;
          end else begin
            state     <= IDLE;
          end
        end

        LATCH: begin
          if (pwrite) pwdata <= hwdata;
          if (dec_miss) begin
`ifdef BRIDGE_PSLVERR_EN
            state     <= ERR1;
            hresp     <= RESP_ERROR;
`else
            state     <= MISS;
            hreadyout <= 1'b1;
            if (!pwrite) hrdata <= '0;
`endif
          end else begin
            state <= SETUP;
            psel  <= dec_sel;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end

        ACCESS: begin
          if (pready) begin
            psel    <= '0;
            penable <= 1'b0;
            if (!pwrite) hrdata <= prdata;
`ifdef BRIDGE_PSLVERR_EN
            if (pslverr) begin
              state <= ERR1;
              hresp <= RESP_ERROR;
            end else begin
              state     <= DONE;
              hreadyout <= 1'b1;
            end
`else
            state     <= DONE;
            hreadyout <= 1'b1;
`endif
          end
        end

`ifdef BRIDGE_PSLVERR_EN
        ERR1: begin
          state     <= ERR2;
          hreadyout <= 1'b1;
        end

        ERR2: begin
          state <= IDLE;
          hresp <= RESP_OKAY;
        end
`endif

        default: begin
          state     <= IDLE;
          hreadyout <= 1'b1;
          psel      <= '0;
          penable   <= 1'b0;
`ifdef BRIDGE_PSLVERR_EN
          hresp     <= RESP_OKAY;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Bench for ahb_apb_bridge_mp: a per-cycle timeline model built from the
// transfer rules, checked every cycle, plus literal pins from the test plan.
module tb_ahb_apb_bridge_mp;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int NUM_SLAVES = 3;
  localparam int SLV_LSB    = 12;
  localparam int SEL_W      = 2;
  localparam int MAXC       = 128;

  localparam int P_HREADY  = 0;
  localparam int P_HRESP   = 1;
  localparam int P_PSEL    = 2;
  localparam int P_PENABLE = 3;
  localparam int P_PWDATA  = 4;
  localparam int P_HRDATA  = 5;
  localparam int P_PADDR   = 6;

  logic                  hclk = 1'b0;
  logic                  hresetn, hwrite, hreadyin, pready, pslverr;
  logic [1:0]            htrans;
  logic [ADDR_W-1:0]     haddr;
  logic [DATA_W-1:0]     hwdata, prdata;
  logic [DATA_W-1:0]     hrdata;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable, pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;

  always #5 hclk = ~hclk;

  ahb_apb_bridge_mp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES), .SLV_LSB(SLV_LSB)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata)
  );

  // Interval k = time between rising edges k and k+1.
  logic        in_rst[MAXC], in_hwrite[MAXC], in_hreadyin[MAXC];
  logic        in_pready[MAXC], in_pslverr[MAXC];
  logic [1:0]  in_htrans[MAXC];
  logic [31:0] in_haddr[MAXC], in_hwdata[MAXC], in_prdata[MAXC];

  logic        ex_hready[MAXC], ex_penable[MAXC], ex_apb_chk[MAXC];
  logic        ex_pwrite[MAXC], ex_pwd_chk[MAXC], hrd_upd[MAXC];
  logic [1:0]  ex_hresp[MAXC];
  logic [2:0]  ex_psel[MAXC];
  logic [31:0] ex_hrdata[MAXC], ex_paddr[MAXC], ex_pwdata[MAXC], hrd_val[MAXC];

  typedef struct {
    int          k;
    string       name;
    int          sig;
    logic [31:0] val;
  } pin_t;
  pin_t pins[$];

  int t, n_cyc, cur_k;
  bit run;
  int n_checks, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cur_k, act, exp);
    end
  endtask

  task automatic pin(input int k, input string name, input int sig, input logic [31:0] val);
    pin_t p;
    p.k = k; p.name = name; p.sig = sig; p.val = val;
    pins.push_back(p);
  endtask

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      P_HREADY:  return 32'(hreadyout);
      P_HRESP:   return 32'(hresp);
      P_PSEL:    return 32'(psel);
      P_PENABLE: return 32'(penable);
      P_PWDATA:  return pwdata;
      P_HRDATA:  return hrdata;
      default:   return paddr;
    endcase
  endfunction

  task automatic init_model();
    for (int k = 0; k < MAXC; k++) begin
      in_rst[k] = 1'b0;       in_htrans[k] = 2'b00;    in_haddr[k] = 32'h0000_1FF0;
      in_hwrite[k] = 1'b1;    in_hwdata[k] = 32'hD0D0_0000 | 32'(k);
      in_hreadyin[k] = 1'b1;  in_pready[k] = 1'b0;     in_pslverr[k] = 1'b0;
      in_prdata[k] = 32'hBAD0_0000 | 32'(k);
      ex_hready[k] = 1'b1;    ex_hresp[k] = 2'b00;     ex_psel[k] = 3'b000;
      ex_penable[k] = 1'b0;   ex_apb_chk[k] = 1'b0;    ex_pwd_chk[k] = 1'b0;
      ex_paddr[k] = '0;       ex_pwrite[k] = 1'b0;     ex_pwdata[k] = '0;
      hrd_upd[k] = 1'b0;      hrd_val[k] = '0;         ex_hrdata[k] = '0;
    end
  endtask

  task automatic reset_outputs(input int k);
    ex_hready[k] = 1'b1; ex_hresp[k] = 2'b00; ex_psel[k] = 3'b000; ex_penable[k] = 1'b0;
    ex_apb_chk[k] = 1'b1; ex_paddr[k] = '0; ex_pwrite[k] = 1'b0;
    ex_pwd_chk[k] = 1'b1; ex_pwdata[k] = '0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      in_rst[t] = 1'b1;
      reset_outputs(t + 1);
      t++;
    end
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] tr, input logic rdy);
    for (int i = 0; i < n; i++) begin
      in_htrans[t] = tr; in_hreadyin[t] = rdy; in_haddr[t] = 32'h0000_1000;
      t++;
    end
  endtask

  // One AHB transfer whose address phase sits in interval t.
  task automatic xfer(input logic [1:0] tr, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int waits, input bit slverr, input bit abort);
    int a, idx, done_k;
    a = t;
    in_htrans[a] = tr; in_haddr[a] = addr; in_hwrite[a] = wr; in_hreadyin[a] = 1'b1;
    in_hwdata[a+1] = wdata;
    ex_hready[a+1] = 1'b0;
    idx = int'((addr >> SLV_LSB) & ((32'd1 << SEL_W) - 32'd1));
    if (idx >= NUM_SLAVES) begin
`ifdef BRIDGE_PSLVERR_EN
      ex_hready[a+2] = 1'b0; ex_hresp[a+2] = 2'b01; ex_hresp[a+3] = 2'b01;
      t = a + 4;
`else
      if (!wr) begin hrd_upd[a+2] = 1'b1; hrd_val[a+2] = '0; end
      t = a + 2;
`endif
      return;
    end
    for (int k = a + 2; k <= a + 3 + waits; k++) begin
      ex_hready[k] = 1'b0;  ex_psel[k] = 3'(1 << idx); ex_penable[k] = (k >= a + 3);
      ex_apb_chk[k] = 1'b1; ex_paddr[k] = addr;        ex_pwrite[k] = wr;
      ex_pwd_chk[k] = wr;   ex_pwdata[k] = wdata;
      if (k >= a + 3) in_pslverr[k] = slverr;
    end
    if (abort) begin
      in_rst[a+3+waits] = 1'b1;
      reset_outputs(a + 4 + waits);
      t = a + 4 + waits;
      return;
    end
    in_pready[a+3+waits] = 1'b1;
    in_prdata[a+3+waits] = rdata;
    done_k = a + 4 + waits;
    if (!wr) begin hrd_upd[done_k] = 1'b1; hrd_val[done_k] = rdata; end
`ifdef BRIDGE_PSLVERR_EN
    if (slverr) begin
      ex_hready[done_k] = 1'b0; ex_hresp[done_k] = 2'b01; ex_hresp[done_k+1] = 2'b01;
      t = done_k + 2;
      return;
    end
`endif
    t = done_k;
  endtask

  task automatic build();
    int a, a2;
    logic [31:0] h;
    init_model();
    t = 0;
    do_reset(2);
    idle_cycles(1, 2'b00, 1'b1);
    idle_cycles(1, 2'b01, 1'b1);
    idle_cycles(1, 2'b10, 1'b0);
    idle_cycles(1, 2'b00, 1'b1);

    a = t; xfer(2'b10, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1'b0);
    pin(a+1, "t1_wait_T1", P_HREADY, 32'd0);
    pin(a+2, "t1_psel_T2", P_PSEL, 32'b010);
    pin(a+2, "t1_penable_T2", P_PENABLE, 32'd0);
    pin(a+3, "t1_penable_T3", P_PENABLE, 32'd1);
    pin(a+3, "t1_pwdata_T3", P_PWDATA, 32'hDEAD_BEEF);
    pin(a+4, "t1_ready_T4", P_HREADY, 32'd1);
    pin(a+4, "t1_hresp_T4", P_HRESP, 32'd0);
    idle_cycles(2, 2'b00, 1'b1);

    a = t; xfer(2'b10, 1'b0, 32'h0000_2000, 32'h0, 32'h1234_5678, 2, 1'b0, 1'b0);
    pin(a+5, "t2_wait_T5", P_HREADY, 32'd0);
    pin(a+5, "t2_paddr_T5", P_PADDR, 32'h0000_2000);
    pin(a+6, "t2_ready_T6", P_HREADY, 32'd1);
    pin(a+6, "t2_hrdata_T6", P_HRDATA, 32'h1234_5678);
    idle_cycles(1, 2'b00, 1'b1);

    a = t;  xfer(2'b10, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0, 0, 1'b0, 1'b0);
    a2 = t; xfer(2'b10, 1'b0, 32'h0000_2008, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    pin(a+2, "t3_psel_first", P_PSEL, 32'b001);
    pin(a+4, "t3_done_ready", P_HREADY, 32'd1);
    pin(a+5, "t3_b2b_latch", P_HREADY, 32'd0);
    pin(a+6, "t3_psel_second", P_PSEL, 32'b100);
    pin(a+9, "t3_hrdata", P_HRDATA, 32'hCAFE_F00D);
    idle_cycles(1, 2'b00, 1'b1);

    a = t; xfer(2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 0, 1'b0, 1'b0);
    pin(a+2, "t4_no_psel", P_PSEL, 32'd0);
`ifdef BRIDGE_PSLVERR_EN
    pin(a+2, "t4_err1_hresp", P_HRESP, 32'd1);
    pin(a+2, "t4_err1_wait", P_HREADY, 32'd0);
    pin(a+3, "t4_err2_hresp", P_HRESP, 32'd1);
    pin(a+3, "t4_err2_ready", P_HREADY, 32'd1);
`else
    pin(a+2, "t4_miss_hrdata", P_HRDATA, 32'd0);
    pin(a+2, "t4_miss_ready", P_HREADY, 32'd1);
    pin(a+2, "t4_miss_okay", P_HRESP, 32'd0);
`endif
    idle_cycles(1, 2'b00, 1'b1);

    a = t; xfer(2'b10, 1'b1, 32'h0000_1100, 32'h0F0F_1234, 32'h0, 1, 1'b1, 1'b0);
`ifdef BRIDGE_PSLVERR_EN
    pin(a+5, "t5_err1_hresp", P_HRESP, 32'd1);
    pin(a+5, "t5_err1_wait", P_HREADY, 32'd0);
    pin(a+6, "t5_err2_hresp", P_HRESP, 32'd1);
    pin(a+6, "t5_err2_ready", P_HREADY, 32'd1);
    pin(a+7, "t5_back_okay", P_HRESP, 32'd0);
`else
    pin(a+5, "t5_okay", P_HRESP, 32'd0);
    pin(a+5, "t5_ready", P_HREADY, 32'd1);
`endif
    idle_cycles(2, 2'b00, 1'b1);

    a = t; xfer(2'b10, 1'b1, 32'h0000_2010, 32'h7777_8888, 32'h0, 1, 1'b0, 1'b1);
    pin(a+4, "t6_penable_access", P_PENABLE, 32'd1);
    pin(a+5, "t6_psel_rst", P_PSEL, 32'd0);
    pin(a+5, "t6_penable_rst", P_PENABLE, 32'd0);
    pin(a+5, "t6_ready_rst", P_HREADY, 32'd1);
    idle_cycles(1, 2'b00, 1'b1);
    a = t; xfer(2'b11, 1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 32'h0, 0, 1'b0, 1'b0);
    pin(a+2, "t6_after_psel", P_PSEL, 32'b001);
    pin(a+3, "t6_after_pwdata", P_PWDATA, 32'h0BAD_CAFE);
    pin(a+4, "t6_after_ready", P_HREADY, 32'd1);
    idle_cycles(3, 2'b00, 1'b1);
    n_cyc = t;

    // hrdata holds until a read completes; a reset clears it.
    h = '0;
    for (int k = 0; k < n_cyc; k++) begin
      if (k >= 1 && in_rst[k-1]) h = '0;
      if (hrd_upd[k]) h = hrd_val[k];
      ex_hrdata[k] = h;
    end
  endtask

  task automatic apply(input int k);
    hresetn  = in_rst[k];    htrans  = in_htrans[k]; haddr  = in_haddr[k];
    hwrite   = in_hwrite[k]; hwdata  = in_hwdata[k]; hreadyin = in_hreadyin[k];
    pready   = in_pready[k]; pslverr = in_pslverr[k]; prdata = in_prdata[k];
  endtask

  always @(negedge hclk) begin
    if (run && cur_k >= 1) begin
      check("hreadyout", 32'(hreadyout), 32'(ex_hready[cur_k]));
      check("hresp", 32'(hresp), 32'(ex_hresp[cur_k]));
      check("psel", 32'(psel), 32'(ex_psel[cur_k]));
      check("penable", 32'(penable), 32'(ex_penable[cur_k]));
      check("hrdata", hrdata, ex_hrdata[cur_k]);
      if (ex_apb_chk[cur_k]) begin
        check("paddr", paddr, ex_paddr[cur_k]);
        check("pwrite", 32'(pwrite), 32'(ex_pwrite[cur_k]));
      end
      if (ex_pwd_chk[cur_k]) check("pwdata", pwdata, ex_pwdata[cur_k]);
      foreach (pins[i]) begin
        if (pins[i].k == cur_k) check(pins[i].name, sig_val(pins[i].sig), pins[i].val);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    run      = 1'b0;
    build();
    cur_k = 0;
    apply(0);
    run = 1'b1;
    for (int k = 1; k < n_cyc; k++) begin
      @(posedge hclk);
      #1;
      cur_k = k;
      apply(k);
    end
    @(posedge hclk);
    #1;
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
